// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op-class enum, opcode constants and class decode for the ALU result selector
// Contents: op_class_t, OP_* opcode constants, decode_class(op) -> op_class_t
package alu_pkg;

   typedef enum logic [1:0] {
      CLS_SHIFT = 2'd0,
      CLS_ADD   = 2'd1,
      CLS_LOGIC = 2'd2,
      CLS_CMP   = 2'd3
   } op_class_t;

   localparam logic [3:0] OP_SLL  = 4'b0000;
   localparam logic [3:0] OP_SRL  = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SUB  = 4'b0011;
   localparam logic [3:0] OP_SRA  = 4'b0100;
   localparam logic [3:0] OP_ROL  = 4'b0101;
   localparam logic [3:0] OP_ADC  = 4'b0110;
   localparam logic [3:0] OP_SBB  = 4'b0111;
   localparam logic [3:0] OP_AND  = 4'b1000;
   localparam logic [3:0] OP_SLT  = 4'b1001;
   localparam logic [3:0] OP_OR   = 4'b1010;
   localparam logic [3:0] OP_SLTU = 4'b1011;
   localparam logic [3:0] OP_XOR  = 4'b1100;
   localparam logic [3:0] OP_EQ   = 4'b1101;
   localparam logic [3:0] OP_NOR  = 4'b1110;
   localparam logic [3:0] OP_NE   = 4'b1111;

   // op[3] splits arithmetic/shift from logical/compare; op[1] or op[0] picks within each half.
   function automatic op_class_t decode_class(input logic [3:0] op);
      if (!op[3])
         return op[1] ? CLS_ADD : CLS_SHIFT;
      else
         return op[0] ? CLS_CMP : CLS_LOGIC;
   endfunction

endpackage

// File: rtl/alu_result_sel_if.sv
// rtl/alu_result_sel_if.sv - upstream result set and downstream buffered result of the ALU selector
// Input side:  in_valid/in_ready, op, shifter, adder, logical, comparator, cin
// Output side: out_valid/out_ready, outp, cout, zero, neg
// slave = selector view, master = pipeline (driver) view
interface alu_result_sel_if #(
   parameter int WIDTH = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       op;
   logic [WIDTH-1:0] shifter;
   logic [WIDTH-1:0] adder;
   logic [WIDTH-1:0] logical;
   logic [WIDTH-1:0] comparator;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] outp;
   logic             cout;
   logic             zero;
   logic             neg;

   modport slave (
      input  in_valid, op, shifter, adder, logical, comparator, cin, out_ready,
      output in_ready, out_valid, outp, cout, zero, neg
   );

   modport master (
      output in_valid, op, shifter, adder, logical, comparator, cin, out_ready,
      input  in_ready, out_valid, outp, cout, zero, neg
   );
endinterface

// File: rtl/alu_skid_fifo.sv
// rtl/alu_skid_fifo.sv - 2-entry valid/ready FIFO holding packed result entries
// Ports: clk, rst_n (sync, active-low), in_valid/in_ready/in_data, out_valid/out_ready/out_data
module alu_skid_fifo #(
   parameter int DW = 7
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data
);

   logic [DW-1:0] mem [2];
   logic          wr_ptr;
   logic          rd_ptr;
   logic [1:0]    count;
   logic          push;
   logic          pop;

   // in_ready looks only at the registered count, never at out_ready.
   assign in_ready  = (count != 2'd2) && rst_n;
   assign out_valid = (count != 2'd0);
   assign out_data  = mem[rd_ptr];
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= in_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop)
            rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/alu_result_sel.sv
// rtl/alu_result_sel.sv - registered ALU result selector with flags, 2-entry output buffer, sticky carry and error count
// Ports: clk, rst_n (sync, active-low), bus (alu_result_sel_if.slave),
//        sticky_clr in, sticky_cout out, err_cnt out [ERRW]
module alu_result_sel
   import alu_pkg::*;
#(
   parameter int         WIDTH    = 4,
   parameter logic [3:0] CLASS_EN = 4'b1111,
   parameter int         ERRW     = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   alu_result_sel_if.slave bus,
   input  logic            sticky_clr,
   output logic            sticky_cout,
   output logic [ERRW-1:0] err_cnt
);

   localparam int EW = WIDTH + 3;

   op_class_t        cls;
   logic             cls_en;
   logic [WIDTH-1:0] res;
   logic             res_c;
   logic [EW-1:0]    in_entry;
   logic [EW-1:0]    head;
   logic             in_ready;
   logic             out_valid;
   logic             accept;
   logic             xfer;

   always_comb begin
      cls    = decode_class(bus.op);
      cls_en = CLASS_EN[cls];
      res    = '0;
      res_c  = 1'b0;
      // A disabled class still produces an entry, forced to zero with no carry.
      if (cls_en) begin
         case (cls)
            CLS_SHIFT: begin res = bus.shifter;    res_c = bus.cin;  end
            CLS_ADD:   begin res = bus.adder;      res_c = bus.cin;  end
            CLS_LOGIC: begin res = bus.logical;    res_c = 1'b0;     end
            CLS_CMP:   begin res = bus.comparator; res_c = bus.cin;  end
            default:   begin res = '0;             res_c = 1'b0;     end
         endcase
      end
   end

   // Entry layout: {cout, zero, neg, result}; flags travel with the data.
   assign in_entry = {res_c, (res == '0), res[WIDTH-1], res};

   alu_skid_fifo #(
      .DW (EW)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (bus.in_valid),
      .in_ready  (in_ready),
      .in_data   (in_entry),
      .out_valid (out_valid),
      .out_ready (bus.out_ready),
      .out_data  (head)
   );

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.outp      = head[WIDTH-1:0];
   assign bus.neg       = head[WIDTH];
   assign bus.zero      = head[WIDTH+1];
   assign bus.cout      = head[WIDTH+2];

   assign accept = bus.in_valid && in_ready;
   assign xfer   = out_valid && bus.out_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sticky_cout <= 1'b0;
         err_cnt     <= '0;
      end else begin
         // Set has priority over a simultaneous clear.
         if (xfer && head[WIDTH+2])
            sticky_cout <= 1'b1;
         else if (sticky_clr)
            sticky_cout <= 1'b0;
         if (accept && !cls_en && (err_cnt != {ERRW{1'b1}}))
            err_cnt <= err_cnt + 1'b1;
      end
   end

endmodule
